// File: rtl/pc_seq_pkg.sv
// Shared state encoding and default geometry for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int DEF_PC_W     = 6;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC priority mux (jump > branch > increment), purely combinational.
// Zero latency; no handshake, the caller decides when the result is applied.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic [PC_W-1:0] PC,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] next_pc,
  output logic            is_redirect
);

  logic [PC_W-1:0] pc_inc;

  // Modulo-2^PC_W wrap falls out of the fixed-width add.
  assign pc_inc = PC + PC_W'(1);

  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc_inc + branch_offset;
    end
  end

  assign is_redirect = jump | branch_taken;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT -> FETCH (wait imem_ready) -> UPDATE (apply controls).
// Fetch-to-fetch spacing is at least 2 cycles; stall holds in UPDATE, halt parks until reset.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_offset,
  output logic             imem_req,
  output logic [PC_W-1:0]  PC,
  output logic             pc_valid,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  state_t          state;
  logic [PC_W-1:0] next_pc;
  logic            is_redirect;

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .PC            (PC),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .is_redirect   (is_redirect)
  );

  assign imem_req = (state == FETCH);
  assign pc_valid = (state == FETCH) && imem_ready;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      PC          <= PC_W'(RESET_PC);
      fetch_count <= '0;
      redirect    <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            state <= UPDATE;
            // Counter saturates at all-ones rather than wrapping.
            if (fetch_count != {CNT_W{1'b1}}) begin
              fetch_count <= fetch_count + CNT_W'(1);
            end
          end
        end
        UPDATE: begin
          if (halt) begin
            state <= HALTED;
          end else if (!stall) begin
            PC       <= next_pc;
            redirect <= is_redirect;
            state    <= FETCH;
          end
        end
        HALTED: state <= HALTED;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a behavioural phase/arithmetic model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic        stall;
  logic        halt;
  logic        jump;
  logic [5:0]  jump_target;
  logic        branch_taken;
  logic [5:0]  branch_offset;
  logic        imem_req;
  logic [5:0]  PC;
  logic        pc_valid;
  logic        redirect;
  logic        halted;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: PC as integer, plus which step of the fetch loop we are in.
  int m_pc;
  int m_count;
  bit m_boot;
  bit m_fetch;
  bit m_halt;
  bit m_redir;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .imem_req      (imem_req),
    .PC            (PC),
    .pc_valid      (pc_valid),
    .redirect      (redirect),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_count = 0;
    m_boot  = 1;
    m_fetch = 0;
    m_halt  = 0;
    m_redir = 0;
  endtask

  task automatic step(input bit r, input bit rdy, input bit st, input bit h,
                      input bit j, input int jt, input bit b, input int off);
    bit exp_req;
    @(negedge clk);
    rst           = r;
    imem_ready    = rdy;
    stall         = st;
    halt          = h;
    jump          = j;
    jump_target   = 6'(jt);
    branch_taken  = b;
    branch_offset = 6'(off);
    #1;
    exp_req = m_fetch && !m_boot && !m_halt;
    chk("pc", 32'(PC), 32'(m_pc));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("pc_valid", 32'(pc_valid), 32'(exp_req && rdy));
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_count", 32'(fetch_count), 32'(m_count));
    // Advance the model across the coming rising edge.
    if (r) begin
      model_reset();
    end else begin
      m_redir = 0;
      if (m_boot) begin
        m_boot  = 0;
        m_fetch = 1;
      end else if (m_halt) begin
        // frozen
      end else if (m_fetch) begin
        if (rdy) begin
          m_fetch = 0;
          if (m_count < 65535) m_count = m_count + 1;
        end
      end else if (h) begin
        m_halt = 1;
      end else if (!st) begin
        if (j) begin
          m_pc    = jt % 64;
          m_redir = 1;
        end else if (b) begin
          m_pc    = ((m_pc + 1 + off) % 64 + 64) % 64;
          m_redir = 1;
        end else begin
          m_pc = (m_pc + 1) % 64;
        end
        m_fetch = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, rdy, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; imem_ready = 0; stall = 0; halt = 0;
    jump = 0; jump_target = '0; branch_taken = 0; branch_offset = '0;
    model_reset();
    @(posedge clk);

    // Free-running fetch with immediate ready.
    idle(10, 1);
    // Memory wait states.
    idle(3, 0);
    idle(2, 1);
    // Negative branch, then jump overriding branch.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 1, -2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 40, 1, -2);
    // Stall hold.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(2, 1);
    // Wrap past 63.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 62, 0, 0);
    idle(8, 1);
    // Halt, stays halted, then reset recovers.
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
    idle(5, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(6, 1);
    // Reset while waiting in FETCH.
    idle(3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 6) == 0,
           int'($urandom_range(0, 63)),
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 63)) - 32);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
